ball_collision_resolver: RTL and testbench

//  Sequential, parametrised resolver for equal-mass ball-ball collisions. Sits in HIT_CONTROLLER

---
 rtl/ball_collision_resolver_if.sv | 41 ++++
 rtl/ball_collision_resolver.sv | 214 +++++++++++++++++++++
 tb/tb_ball_collision_resolver.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ball_collision_resolver_if.sv
// Ball-pair request/result bundle for ball_collision_resolver.
// BALL_COLLISION_RESTITUTION_EN adds the restitution coefficient and its FRAC_BITS parameter.
interface ball_collision_resolver_if #(
  parameter int unsigned W = 11
`ifdef BALL_COLLISION_RESTITUTION_EN
  , parameter int unsigned FRAC_BITS = 8
`endif
);
  logic                startCollision;
  logic signed [W-1:0] posX_1, posY_1, velX_1, velY_1;
  logic signed [W-1:0] posX_2, posY_2, velX_2, velY_2;
`ifdef BALL_COLLISION_RESTITUTION_EN
  logic [FRAC_BITS:0]  restitution;
`endif
  logic signed [W-1:0] velXOut_1, velYOut_1, velXOut_2, velYOut_2;
  logic                busy, done, collisionOccurred;

`ifdef BALL_COLLISION_RESTITUTION_EN
  modport master (
    output startCollision, posX_1, posY_1, velX_1, velY_1,
           posX_2, posY_2, velX_2, velY_2, restitution,
    input  velXOut_1, velYOut_1, velXOut_2, velYOut_2, busy, done, collisionOccurred
  );
  modport slave (
    input  startCollision, posX_1, posY_1, velX_1, velY_1,
           posX_2, posY_2, velX_2, velY_2, restitution,
    output velXOut_1, velYOut_1, velXOut_2, velYOut_2, busy, done, collisionOccurred
  );
`else
  modport master (
    output startCollision, posX_1, posY_1, velX_1, velY_1,
           posX_2, posY_2, velX_2, velY_2,
    input  velXOut_1, velYOut_1, velXOut_2, velYOut_2, busy, done, collisionOccurred
  );
  modport slave (
    input  startCollision, posX_1, posY_1, velX_1, velY_1,
           posX_2, posY_2, velX_2, velY_2,
    output velXOut_1, velYOut_1, velXOut_2, velYOut_2, busy, done, collisionOccurred
  );
`endif
endinterface

// File: rtl/ball_collision_resolver.sv
// Equal-mass ball-ball collision resolver: k = (dv.d)/|d|^2 via restoring divider, v1 -= k*d, v2 += k*d.
// Define BALL_COLLISION_RESTITUTION_EN to add the restitution input and its extra scaling cycle.
module ball_collision_resolver #(
  parameter int unsigned W         = 11,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic                      clk,
  input  logic                      resetN,
  ball_collision_resolver_if.slave  bus
);

  localparam int unsigned DW         = W + 1;
  localparam int unsigned DOT_W      = 2 * W + 2;
  localparam int unsigned NUM_W      = 2 * W + 2 + FRAC_BITS;
  localparam int unsigned DIV_CYCLES = NUM_W;
  localparam int unsigned CNT_W      = $clog2(DIV_CYCLES + 1);
  localparam int unsigned PW         = NUM_W + DW + 1;

  localparam logic signed [PW-1:0] RND  = PW'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [PW-1:0] VMAX = PW'((1 << (W - 1)) - 1);
  localparam logic signed [PW-1:0] VMIN = ~VMAX;

`ifdef BALL_COLLISION_RESTITUTION_EN
  localparam int unsigned        KW    = NUM_W + FRAC_BITS + 2;
  localparam logic [KW-1:0]      ONE_K = KW'(1) << FRAC_BITS;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_DIFF, S_DOT, S_DIV, S_SCALE, S_APPLY, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [W-1:0]  px1_q, py1_q, vx1_q, vy1_q;
  logic signed [W-1:0]  px2_q, py2_q, vx2_q, vy2_q;
`ifdef BALL_COLLISION_RESTITUTION_EN
  logic [FRAC_BITS:0]   e_q;
`endif
  logic signed [DW-1:0] dx_q, dy_q, dvx_q, dvy_q;
  logic [DOT_W-1:0]     nsq_q, rem_q;
  logic [NUM_W-1:0]     dq_q;
  logic [CNT_W-1:0]     cnt_q;
  logic signed [W-1:0]  vox1_q, voy1_q, vox2_q, voy2_q;
  logic                 busy_q, done_q, coll_q;

  logic                 latch_c, skip_c, div_init_c, div_step_c, apply_c;
`ifdef BALL_COLLISION_RESTITUTION_EN
  logic                 scale_c;
`endif
  logic                 busy_d, done_d;

  logic signed [DOT_W-1:0] dot_c;
  logic [DOT_W-1:0]        nsq_c;
  logic [DOT_W:0]          rem_sh_c;
  logic                    fit_c;
  logic signed [PW-1:0]    k_c, px_c, py_c;
  logic signed [W-1:0]     nvx1_c, nvy1_c, nvx2_c, nvy2_c;

  function automatic logic signed [W-1:0] sat(input logic signed [PW-1:0] x);
    if (x > VMAX)      return W'(VMAX);
    else if (x < VMIN) return W'(VMIN);
    else               return W'(x);
  endfunction

  // Dot product and squared distance of the latched difference vectors
  assign dot_c = DOT_W'(dvx_q) * DOT_W'(dx_q) + DOT_W'(dvy_q) * DOT_W'(dy_q);
  assign nsq_c = DOT_W'(dx_q) * DOT_W'(dx_q) + DOT_W'(dy_q) * DOT_W'(dy_q);

  // One restoring-division step: dq_q shifts dividend bits out and quotient bits in
  assign rem_sh_c = {rem_q, dq_q[NUM_W-1]};
  assign fit_c    = (rem_sh_c >= {1'b0, nsq_q});

  // Impulse per axis, rounded to nearest, then saturated velocity update
  assign k_c    = PW'(dq_q);
  assign px_c   = (k_c * PW'(dx_q) + RND) >>> FRAC_BITS;
  assign py_c   = (k_c * PW'(dy_q) + RND) >>> FRAC_BITS;
  assign nvx1_c = sat(PW'(vx1_q) - px_c);
  assign nvy1_c = sat(PW'(vy1_q) - py_c);
  assign nvx2_c = sat(PW'(vx2_q) + px_c);
  assign nvy2_c = sat(PW'(vy2_q) + py_c);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    latch_c    = 1'b0;
    skip_c     = 1'b0;
    div_init_c = 1'b0;
    div_step_c = 1'b0;
    apply_c    = 1'b0;
`ifdef BALL_COLLISION_RESTITUTION_EN
    scale_c    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.startCollision) begin
          latch_c = 1'b1;
          state_d = S_DIFF;
        end
      end
      S_DIFF: state_d = S_DOT;
      S_DOT: begin
        // Coincident centres or separating balls leave velocities untouched
        if (nsq_c == '0 || dot_c[DOT_W-1] || dot_c == '0) begin
          skip_c  = 1'b1;
          state_d = S_DONE;
        end else begin
          div_init_c = 1'b1;
          state_d    = S_DIV;
        end
      end
      S_DIV: begin
        div_step_c = 1'b1;
        if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
`ifdef BALL_COLLISION_RESTITUTION_EN
          state_d = S_SCALE;
`else
          state_d = S_APPLY;
`endif
        end
      end
`ifdef BALL_COLLISION_RESTITUTION_EN
      S_SCALE: begin
        scale_c = 1'b1;
        state_d = S_APPLY;
      end
`endif
      S_APPLY: begin
        apply_c = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      px1_q  <= '0; py1_q <= '0; vx1_q <= '0; vy1_q <= '0;
      px2_q  <= '0; py2_q <= '0; vx2_q <= '0; vy2_q <= '0;
`ifdef BALL_COLLISION_RESTITUTION_EN
      e_q    <= '0;
`endif
      dx_q   <= '0; dy_q  <= '0; dvx_q <= '0; dvy_q <= '0;
      nsq_q  <= '0;
      rem_q  <= '0;
      dq_q   <= '0;
      cnt_q  <= '0;
      vox1_q <= '0; voy1_q <= '0; vox2_q <= '0; voy2_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (latch_c) begin
        px1_q <= bus.posX_1; py1_q <= bus.posY_1;
        vx1_q <= bus.velX_1; vy1_q <= bus.velY_1;
        px2_q <= bus.posX_2; py2_q <= bus.posY_2;
        vx2_q <= bus.velX_2; vy2_q <= bus.velY_2;
`ifdef BALL_COLLISION_RESTITUTION_EN
        e_q   <= bus.restitution;
`endif
      end
      if (state_q == S_DIFF) begin
        dx_q  <= DW'(px2_q) - DW'(px1_q);
        dy_q  <= DW'(py2_q) - DW'(py1_q);
        dvx_q <= DW'(vx1_q) - DW'(vx2_q);
        dvy_q <= DW'(vy1_q) - DW'(vy2_q);
      end
      if (div_init_c) begin
        nsq_q <= nsq_c;
        rem_q <= '0;
        dq_q  <= NUM_W'(dot_c) << FRAC_BITS;
        cnt_q <= '0;
      end
      if (div_step_c) begin
        rem_q <= fit_c ? DOT_W'(rem_sh_c - {1'b0, nsq_q}) : DOT_W'(rem_sh_c);
        dq_q  <= {dq_q[NUM_W-2:0], fit_c};
        cnt_q <= cnt_q + CNT_W'(1);
      end
`ifdef BALL_COLLISION_RESTITUTION_EN
      // k' = k*(1+e)/2, truncated
      if (scale_c) begin
        dq_q <= NUM_W'((KW'(dq_q) * (ONE_K + KW'(e_q))) >> (FRAC_BITS + 1));
      end
`endif
      if (skip_c) begin
        vox1_q <= vx1_q; voy1_q <= vy1_q;
        vox2_q <= vx2_q; voy2_q <= vy2_q;
        coll_q <= 1'b0;
      end
      if (apply_c) begin
        vox1_q <= nvx1_c; voy1_q <= nvy1_c;
        vox2_q <= nvx2_c; voy2_q <= nvy2_c;
        coll_q <= 1'b1;
      end
    end
  end

  assign bus.velXOut_1         = vox1_q;
  assign bus.velYOut_1         = voy1_q;
  assign bus.velXOut_2         = vox2_q;
  assign bus.velYOut_2         = voy2_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.collisionOccurred = coll_q;

endmodule

// File: tb/tb_ball_collision_resolver.sv
// Scoreboard bench for ball_collision_resolver: directed cases plus random pairs against an arithmetic model.
// Honours BALL_COLLISION_RESTITUTION_EN when defined.
module tb_ball_collision_resolver;

  localparam int unsigned W         = 11;
  localparam int unsigned FRAC_BITS = 8;
  localparam int unsigned NUM_W     = 2 * W + 2 + FRAC_BITS;
  localparam int          ONE       = 1 << FRAC_BITS;
  localparam int          VMAX      = (1 << (W - 1)) - 1;
  localparam int          VMIN      = -(1 << (W - 1));
`ifdef BALL_COLLISION_RESTITUTION_EN
  localparam int          LONG_LAT  = int'(NUM_W) + 5;
`else
  localparam int          LONG_LAT  = int'(NUM_W) + 4;
`endif
  localparam int          BOUND     = 200;

  typedef struct {
    int     v1x, v1y, v2x, v2y;
    bit     coll;
    longint cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   resetN;
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;
  exp_t   sb[$];
  exp_t   last;

`ifdef BALL_COLLISION_RESTITUTION_EN
  ball_collision_resolver_if #(.W(W), .FRAC_BITS(FRAC_BITS)) bus ();
`else
  ball_collision_resolver_if #(.W(W)) bus ();
`endif

  ball_collision_resolver #(.W(W), .FRAC_BITS(FRAC_BITS)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int clamp(input longint x);
    if (x > VMAX) return VMAX;
    if (x < VMIN) return VMIN;
    return int'(x);
  endfunction

  // Physics-level reference: impulse along the centre line, Q-format k, rounded per axis
  function automatic exp_t model(input int p1x, p1y, v1x, v1y, p2x, p2y, v2x, v2y, e);
    exp_t   m;
    longint dx, dy, dvx, dvy, dot, nsq, k, rx, ry;
    m.v1x = v1x; m.v1y = v1y; m.v2x = v2x; m.v2y = v2y;
    m.coll = 1'b0;
    m.cyc  = 3;
    dx  = longint'(p2x) - longint'(p1x);
    dy  = longint'(p2y) - longint'(p1y);
    dvx = longint'(v1x) - longint'(v2x);
    dvy = longint'(v1y) - longint'(v2y);
    dot = dvx * dx + dvy * dy;
    nsq = dx * dx + dy * dy;
    if (nsq == 0 || dot <= 0) return m;
    k  = (dot * ONE) / nsq;
    k  = (k * (ONE + e)) / (2 * ONE);
    rx = (k * dx + ONE / 2) >>> FRAC_BITS;
    ry = (k * dy + ONE / 2) >>> FRAC_BITS;
    m.v1x = clamp(v1x - rx); m.v1y = clamp(v1y - ry);
    m.v2x = clamp(v2x + rx); m.v2y = clamp(v2y + ry);
    m.coll = 1'b1;
    m.cyc  = LONG_LAT;
    return m;
  endfunction

  task automatic drive(input int p1x, p1y, v1x, v1y, p2x, p2y, v2x, v2y, input bit start);
    bus.posX_1 = W'(p1x); bus.posY_1 = W'(p1y);
    bus.velX_1 = W'(v1x); bus.velY_1 = W'(v1y);
    bus.posX_2 = W'(p2x); bus.posY_2 = W'(p2y);
    bus.velX_2 = W'(v2x); bus.velY_2 = W'(v2y);
    bus.startCollision = start;
  endtask

  task automatic scramble();
    drive(int'($urandom), int'($urandom), int'($urandom), int'($urandom),
          int'($urandom), int'($urandom), int'($urandom), int'($urandom), 1'b0);
`ifdef BALL_COLLISION_RESTITUTION_EN
    bus.restitution = (FRAC_BITS + 1)'($urandom_range(0, ONE));
`endif
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.done) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%0b done=%0b after %0d cycles, want idle", bus.busy, bus.done, n);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within %0d cycles, want a done pulse", BOUND);
    end
  endtask

  task automatic issue(input int p1x, p1y, v1x, v1y, p2x, p2y, v2x, v2y, e, input bit push);
    exp_t m;
    wait_idle();
    drive(p1x, p1y, v1x, v1y, p2x, p2y, v2x, v2y, 1'b1);
`ifdef BALL_COLLISION_RESTITUTION_EN
    bus.restitution = (FRAC_BITS + 1)'(e);
`endif
    if (push) begin
      m = model(p1x, p1y, v1x, v1y, p2x, p2y, v2x, v2y, e);
      m.cyc = cyc + m.cyc;
      sb.push_back(m);
    end
    @(negedge clk);
    scramble();
  endtask

  function automatic int rand_v();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 40)) - 20;
    return int'($urandom_range(0, 2047)) - 1024;
  endfunction

  function automatic int rand_e();
`ifdef BALL_COLLISION_RESTITUTION_EN
    return int'($urandom_range(0, ONE));
`else
    return ONE;
`endif
  endfunction

  // Monitor: pops on every done, otherwise checks the held result
  always @(negedge clk) begin
    int ax, ay, bx, by;
    exp_t ex;
    ax = int'(bus.velXOut_1); ay = int'(bus.velYOut_1);
    bx = int'(bus.velXOut_2); by = int'(bus.velYOut_2);
    if (!resetN) begin
      last = '{0, 0, 0, 0, 1'b0, 0};
      if (bus.done) begin
        checks++; errors++;
        $display("FAIL done_in_reset: done=1, want 0");
      end
    end else if (bus.done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: done at cycle %0d with no request pending", cyc);
      end else begin
        ex = sb.pop_front();
        checks++;
        if (ax != ex.v1x || ay != ex.v1y || bx != ex.v2x || by != ex.v2y ||
            bus.collisionOccurred != ex.coll) begin
          errors++;
          $display("FAIL result: got v1=(%0d,%0d) v2=(%0d,%0d) coll=%0b, want v1=(%0d,%0d) v2=(%0d,%0d) coll=%0b",
                   ax, ay, bx, by, bus.collisionOccurred, ex.v1x, ex.v1y, ex.v2x, ex.v2y, ex.coll);
        end
        checks++;
        if (cyc != ex.cyc) begin
          errors++;
          $display("FAIL latency: done at cycle %0d, want %0d", cyc, ex.cyc);
        end
        checks++;
        if (!bus.busy) begin
          errors++;
          $display("FAIL busy_at_done: busy=0, want 1");
        end
        last = ex;
      end
    end else begin
      checks++;
      if (ax != last.v1x || ay != last.v1y || bx != last.v2x || by != last.v2y) begin
        errors++;
        $display("FAIL hold: got v1=(%0d,%0d) v2=(%0d,%0d), want v1=(%0d,%0d) v2=(%0d,%0d)",
                 ax, ay, bx, by, last.v1x, last.v1y, last.v2x, last.v2y);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p1x, p1y, dxo, dyo;
    resetN = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
`ifdef BALL_COLLISION_RESTITUTION_EN
    bus.restitution = (FRAC_BITS + 1)'(ONE);
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy || bus.done || bus.collisionOccurred || bus.velXOut_1 != 0 || bus.velYOut_1 != 0 ||
        bus.velXOut_2 != 0 || bus.velYOut_2 != 0) begin
      errors++;
      $display("FAIL reset_state: busy=%0b done=%0b coll=%0b, want all outputs 0",
               bus.busy, bus.done, bus.collisionOccurred);
    end
    resetN = 1'b1;
    @(negedge clk);

    // Head-on, diagonal, separating, coincident
    issue(100, 100, 4, 0, 116, 100, 0, 0, ONE, 1'b1);
    issue(200, 200, 6, 0, 210, 210, 0, 0, ONE, 1'b1);
    issue(100, 100, -4, 0, 116, 100, 0, 0, ONE, 1'b1);
    issue(50, 50, 3, 1, 50, 50, 0, 0, ONE, 1'b1);

    // Start during the divide must be ignored
    issue(100, 100, 4, 0, 116, 100, 0, 0, ONE, 1'b1);
    repeat (6) @(negedge clk);
    drive(10, 10, 9, 9, 15, 12, -7, 3, 1'b1);
    @(negedge clk);
    scramble();

    // Start coinciding with done must be ignored
    issue(200, 200, 6, 0, 210, 210, 0, 0, ONE, 1'b1);
    wait_done();
    drive(0, 0, 5, 5, 3, 4, 0, 0, 1'b1);
    @(negedge clk);
    scramble();
    checks++;
    if (bus.busy || bus.done) begin
      errors++;
      $display("FAIL start_at_done: busy=%0b done=%0b, want 0 0", bus.busy, bus.done);
    end

    // Reset during the divide aborts without a done
    issue(100, 100, 4, 0, 116, 100, 0, 0, ONE, 1'b0);
    repeat (10) @(negedge clk);
    resetN = 1'b0;
    #1;
    checks++;
    if (bus.busy || bus.done || bus.collisionOccurred || bus.velXOut_1 != 0 || bus.velYOut_1 != 0 ||
        bus.velXOut_2 != 0 || bus.velYOut_2 != 0) begin
      errors++;
      $display("FAIL mid_reset: busy=%0b done=%0b coll=%0b, want all outputs 0",
               bus.busy, bus.done, bus.collisionOccurred);
    end
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    issue(100, 100, 4, 0, 116, 100, 0, 0, ONE, 1'b1);

`ifdef BALL_COLLISION_RESTITUTION_EN
    issue(100, 100, 4, 0, 116, 100, 0, 0, ONE / 2, 1'b1);
    issue(100, 100, 4, 0, 116, 100, 0, 0, 0, 1'b1);
`endif

    // Random pairs, mostly near each other so many actually collide
    for (int i = 0; i < 150; i++) begin
      p1x = int'($urandom_range(0, 1800)) - 900;
      p1y = int'($urandom_range(0, 1800)) - 900;
      dxo = int'($urandom_range(0, 60)) - 30;
      dyo = int'($urandom_range(0, 60)) - 30;
      if ($urandom_range(0, 9) == 0) begin
        dxo = int'($urandom_range(0, 200)) - 100;
        dyo = 0;
      end
      issue(p1x, p1y, rand_v(), rand_v(), p1x + dxo, p1y + dyo, rand_v(), rand_v(), rand_e(), 1'b1);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d results never delivered, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
